// File: rtl/fireball_pkg.sv
// fireball_pkg: shared definitions for the fireball projectile and its renderer.
//   fb_state_t  - projectile life-cycle states
//   FB_SPRITE_W - fireball sprite width in pixels
//   FB_SPRITE_H - fireball sprite height in pixels
package fireball_pkg;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_FLY,
    FB_COOLDOWN
  } fb_state_t;

  localparam int FB_SPRITE_W = 16;
  localparam int FB_SPRITE_H = 11;

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the asynchronous frame_clk into the clk domain and
// produces a one-cycle pulse per rising edge.
//   clk        in  system clock
//   rst        in  asynchronous, active-high reset
//   frame_clk  in  vsync-rate signal, asynchronous to clk
//   frame_tick out one-clk pulse, 3 clk cycles after a frame_clk rise
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= frame_clk;
      sync2      <= sync1;
      sync2_d    <= sync2;
      frame_tick <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/fireball_projectile.sv
// fireball_projectile: life cycle of one fireball (launch, per-frame motion,
// hit detection against the opposing fighter, post-shot cooldown).
//   Clk, Reset             clock; asynchronous active-high reset
//   frame_clk              vsync-rate signal, synchronized internally
//   player_or_npc          1: fire rightward, 0: fire leftward
//   fire_req               launch request, taken in IDLE only
//   shooter_x/y            shooter top-left corner
//   target_x/y/w/h         opponent hitbox
//   proj_x_curr/proj_y_curr fireball top-left corner
//   fire_active            fireball visible and moving
//   hit                    one-cycle pulse on impact
//   ready                  high in IDLE only
module fireball_projectile
  import fireball_pkg::*;
#(
  parameter int SPRITE_W        = FB_SPRITE_W,
  parameter int SPRITE_H        = FB_SPRITE_H,
  parameter int SHOOTER_W       = 32,
  parameter int SPAWN_Y_OFS     = 20,
  parameter int SPEED           = 4,
  parameter int SCREEN_W        = 640,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       player_or_npc,
  input  logic       fire_req,
  input  logic [9:0] shooter_x,
  input  logic [9:0] shooter_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  logic [9:0] target_w,
  input  logic [9:0] target_h,
  output logic [9:0] proj_x_curr,
  output logic [9:0] proj_y_curr,
  output logic       fire_active,
  output logic       hit,
  output logic       ready
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [10:0] X_MAX = 11'(SCREEN_W - SPRITE_W);

  logic frame_tick;

  frame_tick_sync u_frame_tick_sync (
    .clk        (Clk),
    .rst        (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  fb_state_t        state_q, state_n;
  logic [9:0]       x_q, x_n;
  logic [9:0]       y_q, y_n;
  logic             dir_q, dir_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             active_q, active_n;
  logic             hit_q, hit_n;
  logic             ready_q, ready_n;

  logic [10:0] spawn_x;
  logic [9:0]  spawn_y;
  logic [10:0] next_x;
  logic        exit_edge;
  logic        overlap;

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    dir_n    = dir_q;
    cnt_n    = cnt_q;
    active_n = active_q;
    hit_n    = 1'b0;

    // A left spawn below zero wraps to a large 11-bit value, so a single
    // upper-bound compare rejects both off-screen cases.
    spawn_x = player_or_npc ? ({1'b0, shooter_x} + 11'(SHOOTER_W))
                            : ({1'b0, shooter_x} - 11'(SPRITE_W));
    spawn_y = shooter_y + 10'(SPAWN_Y_OFS);

    next_x    = dir_q ? ({1'b0, x_q} + 11'(SPEED)) : ({1'b0, x_q} - 11'(SPEED));
    exit_edge = dir_q ? (({1'b0, x_q} + 11'(SPEED)) > X_MAX) : (x_q < 10'(SPEED));
    overlap   = (next_x < ({1'b0, target_x} + {1'b0, target_w})) &&
                ({1'b0, target_x} < (next_x + 11'(SPRITE_W))) &&
                ({1'b0, y_q} < ({1'b0, target_y} + {1'b0, target_h})) &&
                ({1'b0, target_y} < ({1'b0, y_q} + 11'(SPRITE_H)));

    case (state_q)
      FB_IDLE: begin
        if (fire_req && !(spawn_x > X_MAX)) begin
          state_n  = FB_FLY;
          x_n      = spawn_x[9:0];
          y_n      = spawn_y;
          dir_n    = player_or_npc;
          active_n = 1'b1;
        end
      end
      FB_FLY: begin
        if (frame_tick) begin
          if (overlap) begin
            hit_n    = 1'b1;
            active_n = 1'b0;
            x_n      = next_x[9:0];
            cnt_n    = CNT_W'(COOLDOWN_FRAMES);
            state_n  = FB_COOLDOWN;
          end else if (exit_edge) begin
            active_n = 1'b0;
            cnt_n    = CNT_W'(COOLDOWN_FRAMES);
            state_n  = FB_COOLDOWN;
          end else begin
            x_n = next_x[9:0];
          end
        end
      end
      FB_COOLDOWN: begin
        // Leaving on the tick that would bring the count to zero also
        // covers a zero-length cooldown.
        if (frame_tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = FB_IDLE;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_n = FB_IDLE;
    endcase

    ready_n = (state_n == FB_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= FB_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      dir_q    <= dir_n;
      cnt_q    <= cnt_n;
      active_q <= active_n;
      hit_q    <= hit_n;
      ready_q  <= ready_n;
    end
  end

  assign proj_x_curr = x_q;
  assign proj_y_curr = y_q;
  assign fire_active = active_q;
  assign hit         = hit_q;
  assign ready       = ready_q;

endmodule

// File: doc/fireball_projectile.md
# fireball_projectile

Owns the life cycle of one fireball: launch from a fighter on request, per-frame horizontal motion, hit detection against the opposing fighter's box, and post-shot cooldown. It produces `proj_x_curr`, `proj_y_curr` and `fire_active`, which the fireball sprite renderer consumes. It also reports hits to the health/score logic. The design instantiates one copy per fighter.

## Interface
- `SPRITE_W`, 16: fireball width in pixels.
- `SPRITE_H`, 11: fireball height in pixels.
- `SHOOTER_W`, 32: fighter sprite width, used for the spawn offset.
- `SPAWN_Y_OFS`, 20: vertical spawn offset below the shooter's top edge.
- `SPEED`, 4: pixels moved per frame.
- `SCREEN_W`, 640: visible width.
- `COOLDOWN_FRAMES`, 30: frames in COOLDOWN before the next launch.
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  asynchronous, active-high.
- `frame_clk`  in  1  vertical-sync-rate signal, asynchronous to `Clk`; treated as data.
- `player_or_npc`  in  1  1: fires rightward (player), 0: fires leftward (npc).
- `fire_req`  in  1  level; a launch is taken on any `Clk` edge where it is high in IDLE.
- `shooter_x`, `shooter_y`  in  10 each  shooter top-left corner.
- `target_x`, `target_y`  in  10 each  opponent hitbox top-left corner.
- `target_w`, `target_h`  in  10 each  opponent hitbox size.
- `proj_x_curr`, `proj_y_curr`  out  10 each  fireball top-left corner.
- `fire_active`  out  1  fireball is visible and moving.
- `hit`  out  1  one-`Clk` pulse on impact.
- `ready`  out  1  high in IDLE only.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-flop synchronizer.
  - Rising-edge detection on the synchronized signal gives `frame_tick`, one `Clk` wide.
- States: IDLE, FLY, COOLDOWN.
- IDLE with `fire_req`=1:
  - Latch the direction from `player_or_npc`.
  - Spawn X: `shooter_x+SHOOTER_W` when the direction is right, `shooter_x-SPRITE_W` when left.
  - Spawn Y: `shooter_y+SPAWN_Y_OFS`.
  - Spawn arithmetic is 11-bit.
  - If the spawn X is below 0 or above `SCREEN_W-SPRITE_W`, the request is dropped and the block stays in IDLE.
  - Otherwise go to FLY with `fire_active`=1.
- FLY on `frame_tick`:
  - Compute `next_x = x ± SPEED`, using the latched direction.
  - Exit test: rightward exits if `x+SPEED > SCREEN_W-SPRITE_W`; leftward exits if `x < SPEED`. No wrap-around.
  - Hit test uses `next_x` (11-bit): `next_x < tx+tw` and `tx < next_x+SPRITE_W` and `y < ty+th` and `ty < y+SPRITE_H`.
  - Hit: pulse `hit`, clear `fire_active`, go to COOLDOWN. Position holds at `next_x`.
  - Exit (miss): clear `fire_active`, go to COOLDOWN, no `hit`.
  - Hit and exit together: hit wins.
  - Otherwise: `x <= next_x`.
  - Y never changes in flight.
- The target inputs are sampled live on each tick; the target may move.
- COOLDOWN:
  - An internal counter is loaded with `COOLDOWN_FRAMES` on entry.
  - It decrements on each `frame_tick`.
  - At 0 the block returns to IDLE.
  - `COOLDOWN_FRAMES`=0 returns to IDLE on the first tick.
- `fire_req` is ignored in FLY and COOLDOWN; requests are not queued.
- `player_or_npc` changes mid-flight have no effect.

## Timing
- Reset values: state IDLE, `proj_x_curr`=0, `proj_y_curr`=0, `fire_active`=0, `hit`=0, `ready`=1. The cooldown counter and synchronizer flops are also 0.
- Reset asserted mid-flight or mid-cooldown clears everything immediately, without waiting for a clock edge.
- Launch latency: `fire_active` and the position are valid on the edge following the sampled `fire_req`.
- `fire_req` and `frame_tick` in the same IDLE cycle: launch only; no motion that cycle.
- Tick latency:
  - `frame_clk` rise to `frame_tick`: 3 `Clk` cycles (2 synchronizer flops plus the edge-detect register).
  - `frame_tick` to the updated position, `hit`, or `fire_active`=0: 1 cycle (registered outputs).
- `hit` is high for exactly one `Clk` per impact, never more than once per launch.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `fireball_pkg` holds:
  - the state enum `fb_state_t {FB_IDLE, FB_FLY, FB_COOLDOWN}`;
  - `FB_SPRITE_W`=16 and `FB_SPRITE_H`=11, shared with the sprite renderer so the two stay consistent.
- Sub-module `frame_tick_sync` contains the synchronizer and rising-edge detect.
- Everything else lives in one FSM plus datapath.

## Test plan
- Player launch: `shooter_x`=100, `shooter_y`=300 → next cycle (`proj_x_curr`, `proj_y_curr`) = (132, 320) and `fire_active`=1. After 5 ticks `proj_x_curr`=152.
- Hit: npc at `target_x`=200, `target_w`=32, `target_y`=300, `target_h`=64. Player fireball at x=180:
  - 1st tick: `next_x`=184 ≥ 200-16=184 is false overlap, since 184+16=200 is not greater than 200. No hit; x=184.
  - 2nd tick: `next_x`=188, `hit` pulses once, `fire_active`=0.
- Left exit: npc launch from `shooter_x`=40 gives spawn x=24. Ticks step x to 20, 16, …, 4, 0. The tick at x=0 exits with no hit, and COOLDOWN is entered.
- Cooldown: with `COOLDOWN_FRAMES`=3 and `fire_req` held high, `ready` returns 1 after the 3rd tick. A relaunch occurs on the next cycle and not earlier.
- Rejected spawn: npc with `shooter_x`=10 → stays in IDLE, `fire_active` stays 0.
- Async Reset pulse mid-FLY at x=300 → all outputs go to their reset values immediately. A launch on the first cycle after Reset deasserts works.
